// File: rtl/capture_arbiter.sv
// -----------------------------------------------------------------------------
// capture_arbiter
//
// Sequences one capture session and shares the single capture-FIFO write port
// between three protocol decoders (uart=0, spi=1, i2c=2). Each decoder has a
// one-entry holding register. A round-robin arbiter grants at most one FIFO
// write per cycle. Each written word is tagged with a protocol id and a
// wrapping sequence number. Bytes lost to contention or back-pressure are
// counted.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   arm          one-cycle pulse, starts a session from IDLE or DONE
//   abort        level, forces IDLE (highest priority)
//   src_en       per-source enable {i2c, spi, uart}
//   src_valid    per-source one-cycle byte strobe {i2c, spi, uart}
//   src_data     {i2c[23:16], spi[15:8], uart[7:0]}
//   fifo_full    FIFO cannot take a write this cycle
//   fifo_wr_en   FIFO write strobe
//   fifo_wr_data {proto_id[1:0], seq[SEQ_W-1:0], byte[7:0]}, zero when idle
//   state        IDLE=00, ARMED=01, CAPTURE=10, DONE=11
//   done         state == DONE
//   words        words written this session
//   drop_cnt     bytes dropped this session, saturating at 255
//
// Handshake: src_valid is a strobe with no ready. A byte is taken only if its
// holding register is empty, or is being written to the FIFO in that same
// cycle. Otherwise the byte is dropped and counted. On the FIFO side,
// !fifo_full acts as ready. fifo_wr_en is asserted only when fifo_full is low,
// so every strobe is a completed write.
// -----------------------------------------------------------------------------
module capture_arbiter #(
   parameter int WORD_LIMIT = 16,
   parameter int SEQ_W      = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm,
   input  logic        abort,
   input  logic [2:0]  src_en,
   input  logic [2:0]  src_valid,
   input  logic [23:0] src_data,
   input  logic        fifo_full,
   output logic        fifo_wr_en,
   output logic [15:0] fifo_wr_data,
   output logic [1:0]  state,
   output logic        done,
   output logic [7:0]  words,
   output logic [7:0]  drop_cnt
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ARMED   = 2'b01,
      S_CAPTURE = 2'b10,
      S_DONE    = 2'b11
   } state_t;

   localparam logic [7:0]       LIMIT   = 8'(WORD_LIMIT);
   localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       pend_vld_q;
   logic [7:0]       pend_data_q [3];
   logic [7:0]       words_q;
   logic [7:0]       drop_q;
   logic [SEQ_W-1:0] seq_q;
   logic [1:0]       rr_q;        // first source to search this cycle

   logic             gnt_any;
   logic [1:0]       gnt_idx;
   logic [2:0]       gnt_vec;
   logic [1:0]       cand;
   logic [2:0]       accept;
   logic [2:0]       drop;
   logic [1:0]       drop_num;
   logic [8:0]       drop_sum;
   logic             capturing;
   logic             enter_armed;
   logic             enter_done;
   logic             clr_pend;

   // Source index successor in uart -> spi -> i2c -> uart order.
   function automatic logic [1:0] wrap_inc(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // Round-robin grant, starting the search at rr_q.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = 2'd0;
      gnt_vec = 3'b000;
      cand    = rr_q;
      if (state_q == S_CAPTURE && !fifo_full) begin
         for (int k = 0; k < 3; k++) begin
            if (!gnt_any && pend_vld_q[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
            cand = wrap_inc(cand);
         end
      end
      if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
   end

   // Accept and drop. abort suppresses accepts because its edge clears the
   // holding registers anyway.
   always_comb begin
      capturing = (state_q == S_ARMED) || (state_q == S_CAPTURE);
      accept    = src_valid & src_en & {3{capturing && !abort}};
      drop      = accept & pend_vld_q & ~gnt_vec;
      drop_num  = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (drop[i]) drop_num = drop_num + 2'd1;
      end
      drop_sum  = {1'b0, drop_q} + {7'd0, drop_num};
   end

   // Next-state logic. abort overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (arm) state_d = S_ARMED;
            S_ARMED:   if (|accept) state_d = S_CAPTURE;
            S_CAPTURE: if (gnt_any && (words_q + 8'd1 == LIMIT)) state_d = S_DONE;
            S_DONE:    if (arm) state_d = S_ARMED;
            default:   state_d = S_IDLE;
         endcase
      end
      enter_armed = (state_d == S_ARMED) && (state_q != S_ARMED);
      enter_done  = (state_d == S_DONE) && (state_q == S_CAPTURE);
      // Bytes still held when the session ends are discarded, not dropped.
      clr_pend    = abort || enter_armed || enter_done;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pend_vld_q <= 3'b000;
         for (int i = 0; i < 3; i++) pend_data_q[i] <= 8'h00;
         words_q    <= 8'h00;
         drop_q     <= 8'h00;
         seq_q      <= '0;
         rr_q       <= 2'd0;
      end else begin
         state_q <= state_d;

         if (enter_armed) begin
            words_q <= 8'h00;
            drop_q  <= 8'h00;
            seq_q   <= '0;
            rr_q    <= 2'd0;
         end else begin
            // A write in the abort cycle still reaches the FIFO, so it is
            // still counted.
            if (gnt_any) begin
               words_q <= words_q + 8'd1;
               seq_q   <= seq_q + SEQ_ONE;
               rr_q    <= wrap_inc(gnt_idx);
            end
            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         end

         for (int i = 0; i < 3; i++) begin
            if (clr_pend) begin
               pend_vld_q[i] <= 1'b0;
            end else if (accept[i] && (!pend_vld_q[i] || gnt_vec[i])) begin
               pend_vld_q[i]  <= 1'b1;
               pend_data_q[i] <= src_data[i*8 +: 8];
            end else if (gnt_vec[i]) begin
               pend_vld_q[i] <= 1'b0;
            end
         end
      end
   end

   assign fifo_wr_en   = gnt_any;
   assign fifo_wr_data = gnt_any ? {gnt_idx, seq_q, pend_data_q[gnt_idx]} : 16'h0000;
   assign state        = state_q;
   assign done         = (state_q == S_DONE);
   assign words        = words_q;
   assign drop_cnt     = drop_q;

endmodule
